// File: rtl/updi_phy_tx.sv
// UPDI single-wire UART transmitter: 8E2 frames from a FWFT FIFO.
// Optional BREAK generation is compiled in with UPDI_PHY_TX_BREAK_EN.
module updi_phy_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int GUARD_BITS   = 2,
    parameter int BREAK_BITS   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic       send_break,
    output logic       tx,
    output logic       tx_oe,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int MAXB = (BREAK_BITS > GUARD_BITS)
                        ? ((BREAK_BITS > 2) ? BREAK_BITS : 2)
                        : ((GUARD_BITS > 2) ? GUARD_BITS : 2);
    localparam int BW   = $clog2(MAXB + 1);
    localparam int GB1  = (GUARD_BITS > 0) ? GUARD_BITS - 1 : 0;
    localparam int BB1  = (BREAK_BITS > 0) ? BREAK_BITS - 1 : 0;

    localparam logic [CW-1:0] CNT_TC = CW'(CLKS_PER_BIT - 1);

`ifdef UPDI_PHY_TX_BREAK_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, GUARD, BREAK_LO, BREAK_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, GUARD
    } state_t;
    logic brk_unused;
    assign brk_unused = send_break;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, idx_n;
    logic [BW-1:0] bit_cnt, bcnt_n;
    logic [7:0]    data_q;
    logic          par_q;
    logic          tx_n, oe_n, done_n, pop, tc;

    assign tc         = (cnt == CNT_TC);
    assign busy       = (state != IDLE);
    assign fifo_rd_en = pop;

    always_comb begin
        state_n = state;
        cnt_n   = tc ? '0 : cnt + CW'(1);
        idx_n   = bit_idx;
        bcnt_n  = bit_cnt;
        pop     = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rst) begin
`ifdef UPDI_PHY_TX_BREAK_EN
                    if (send_break) begin
                        state_n = BREAK_LO;
                        bcnt_n  = '0;
                    end else
`endif
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end
                end
            end
            START: if (tc) begin
                state_n = DATA;
                idx_n   = '0;
            end
            DATA: if (tc) begin
                if (bit_idx == 3'd7) state_n = PARITY;
                else idx_n = bit_idx + 3'd1;
            end
            PARITY: if (tc) begin
                state_n = STOP;
                bcnt_n  = '0;
            end
            STOP: if (tc) begin
                if (bit_cnt == BW'(1)) begin
                    bcnt_n = '0;
                    if (GUARD_BITS == 0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = GUARD;
                    end
                end else begin
                    bcnt_n = bit_cnt + BW'(1);
                end
            end
            GUARD: if (tc) begin
                if (bit_cnt == BW'(GB1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    bcnt_n = bit_cnt + BW'(1);
                end
            end
`ifdef UPDI_PHY_TX_BREAK_EN
            BREAK_LO: if (tc) begin
                if (bit_cnt == BW'(BB1)) begin
                    state_n = BREAK_STOP;
                    bcnt_n  = '0;
                end else begin
                    bcnt_n = bit_cnt + BW'(1);
                end
            end
            BREAK_STOP: if (tc) begin
                if (bit_cnt == BW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    bcnt_n = bit_cnt + BW'(1);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Pin outputs are registered, so they follow the next state.
    always_comb begin
        tx_n = 1'b1;
        oe_n = 1'b1;
        unique case (state_n)
            IDLE:     oe_n = 1'b0;
            START:    tx_n = 1'b0;
            DATA:     tx_n = data_q[idx_n];
            PARITY:   tx_n = par_q;
`ifdef UPDI_PHY_TX_BREAK_EN
            BREAK_LO: tx_n = 1'b0;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            tx         <= 1'b1;
            tx_oe      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= idx_n;
            bit_cnt    <= bcnt_n;
            tx         <= tx_n;
            tx_oe      <= oe_n;
            frame_done <= done_n;
            if (pop) begin
                data_q <= fifo_data;
                par_q  <= ^fifo_data;
            end
        end
    end

endmodule
